// File: rtl/sa_pkg.sv
// sa_pkg: types and defaults shared by the systolic-array input feeder and output data mover.
package sa_pkg;
  localparam int SA_PE_SIZE = 16;
  localparam int SA_FIFO_DATA_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} sa_state_t;
  function automatic int lane_msb(int lane, int lane_w, int word_w);
    return word_w - 1 - lane * lane_w;
  endfunction
endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: enable-gated shift of one lane's data and valid by DEPTH cycles.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);
  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n, i_en};
    assign o_data = i_data;
    assign o_valid = i_valid;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < DEPTH; j++) r_data[j] <= '0;
        r_vld <= '0;
      end else if (i_en) begin
        r_data[0] <= i_data;
        r_vld[0] <= i_valid;
        for (int j = 1; j < DEPTH; j++) begin
          r_data[j] <= r_data[j-1];
          r_vld[j] <= r_vld[j-1];
        end
      end
    end
    assign o_data = r_data[DEPTH-1];
    assign o_valid = r_vld[DEPTH-1];
  end
endmodule

// File: rtl/sa_input_feeder.sv
// sa_input_feeder: reads a tile of BRAM words and feeds per-lane FIFOs with a diagonal skew.
module sa_input_feeder
  import sa_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = SA_FIFO_DATA_WIDTH,
  parameter int PE_SIZE         = SA_PE_SIZE,
  parameter int MEM_ADDR_WIDTH  = 7,
  parameter int MEM_DATA_WIDTH  = PE_SIZE * FIFO_DATA_WIDTH,
  parameter int NUM_ROWS        = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start_i,
  input  logic [MEM_ADDR_WIDTH-1:0]           base_addr_i,
  output logic                                mem_ce_o,
  output logic [MEM_ADDR_WIDTH-1:0]           mem_addr_o,
  input  logic [MEM_DATA_WIDTH-1:0]           mem_q_i,
  input  logic [PE_SIZE-1:0]                  full_i,
  output logic [PE_SIZE-1:0]                  wen_o,
  output logic [FIFO_DATA_WIDTH*PE_SIZE-1:0]  wdata_o,
  output logic                                busy_o,
  output logic                                done_o
);
  localparam int CW = $clog2(NUM_ROWS + 1);
  sa_state_t r_state, w_next;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [CW-1:0] r_rcnt, r_wcnt;
  logic r_vld;
  logic w_stall, w_start;
  logic [PE_SIZE-1:0] w_lane_vld;
  logic [FIFO_DATA_WIDTH-1:0] w_lane_data [PE_SIZE];
  assign w_stall = |full_i;
  assign w_start = r_state == IDLE && start_i;
  assign mem_ce_o = r_state == READ && !w_stall;
  assign mem_addr_o = r_addr;
  assign busy_o = r_state != IDLE;
  assign wen_o = w_stall ? '0 : w_lane_vld;
  // the last lane is the slowest, so its final write closes the tile
  assign done_o = r_state == DRAIN && wen_o[PE_SIZE-1] && r_wcnt == CW'(NUM_ROWS - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = start_i ? READ : IDLE;
      READ:    w_next = (mem_ce_o && r_rcnt == CW'(NUM_ROWS - 1)) ? DRAIN : READ;
      DRAIN:   w_next = done_o ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_rcnt <= '0;
      r_wcnt <= '0;
      r_vld <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr <= base_addr_i;
        r_rcnt <= '0;
        r_wcnt <= '0;
      end else begin
        if (mem_ce_o) begin
          r_addr <= r_addr + MEM_ADDR_WIDTH'(1);
          r_rcnt <= r_rcnt + CW'(1);
        end
        if (wen_o[PE_SIZE-1]) r_wcnt <= r_wcnt + CW'(1);
      end
      if (!w_stall) r_vld <= mem_ce_o;
    end
  end
  for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
    localparam int HI = lane_msb(i, FIFO_DATA_WIDTH, MEM_DATA_WIDTH);
    skew_delay_line #(.DEPTH(i), .WIDTH(FIFO_DATA_WIDTH)) u_dly (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (!w_stall),
      .i_data  (mem_q_i[HI -: FIFO_DATA_WIDTH]),
      .i_valid (r_vld),
      .o_data  (w_lane_data[i]),
      .o_valid (w_lane_vld[i])
    );
    assign wdata_o[HI -: FIFO_DATA_WIDTH] = w_lane_vld[i] ? w_lane_data[i] : '0;
  end
endmodule

// File: tb/tb_sa_input_feeder.sv
// tb_sa_input_feeder: randomized tiles against a cycle-level scoreboard of the feeder's timing rules.
module tb_sa_input_feeder;
  localparam int P = 4, N = 3, W = 8, AW = 7, DW = P * W;
  localparam int P2 = 16, DW2 = P2 * W;
  typedef struct {int lane; int data; int rel;} wr_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start_i = 1'b0, start_b = 1'b0;
  logic [AW-1:0] base_addr_i = '0, base_b = '0;
  logic mem_ce_o, ce_b, busy_o, busy_b, done_o, done_b;
  logic [AW-1:0] mem_addr_o, addr_b;
  logic [DW-1:0] mem_q_i, wdata_o;
  logic [DW2-1:0] q_b, wdata_b;
  logic [P-1:0] full_i = '0, wen_o;
  logic [P2-1:0] full_b = '0, wen_b;
  logic [DW-1:0] mem [128];
  logic [DW2-1:0] mem_b [128];
  int cyc = 0, t0 = 0, tb0 = 0, tests = 0, fails = 0;
  int done_n = 0, done_rel = -1, viol = 0;
  wr_t wr_q[$];
  int addr_q[$], ce_c[$];
  int first_b [P2], cnt_b [P2], data_b [P2];
  int ce_b_n = 0, ce_b_rel = -1, done_b_rel = -1;

  sa_input_feeder #(.FIFO_DATA_WIDTH(W), .PE_SIZE(P), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .NUM_ROWS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i), .mem_ce_o(mem_ce_o),
    .mem_addr_o(mem_addr_o), .mem_q_i(mem_q_i), .full_i(full_i), .wen_o(wen_o), .wdata_o(wdata_o),
    .busy_o(busy_o), .done_o(done_o));
  sa_input_feeder #(.FIFO_DATA_WIDTH(W), .PE_SIZE(P2), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW2), .NUM_ROWS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .base_addr_i(base_b), .mem_ce_o(ce_b),
    .mem_addr_o(addr_b), .mem_q_i(q_b), .full_i(full_b), .wen_o(wen_b), .wdata_o(wdata_b),
    .busy_o(busy_b), .done_o(done_b));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_ce_o) mem_q_i <= mem[mem_addr_o];
    if (ce_b) q_b <= mem_b[addr_b];
  end

  always @(negedge clk) begin
    for (int i = 0; i < P; i++)
      if (wen_o[i]) begin
        wr_q.push_back('{i, int'(wdata_o[DW-1-i*W -: W]), cyc - t0});
        if (full_i[i]) viol++;
      end
    if (mem_ce_o) begin
      addr_q.push_back(int'(mem_addr_o));
      ce_c.push_back(cyc - t0);
    end
    if (done_o) begin
      done_n++;
      done_rel = cyc - t0;
    end
    for (int i = 0; i < P2; i++)
      if (wen_b[i]) begin
        if (cnt_b[i] == 0) first_b[i] = cyc - tb0;
        cnt_b[i]++;
        data_b[i] = int'(wdata_b[DW2-1-i*W -: W]);
      end
    if (ce_b) begin
      ce_b_n++;
      ce_b_rel = cyc - tb0;
    end
    if (done_b) done_b_rel = cyc - tb0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // nominal cycle e pushed later by every stall cycle at or before it
  function automatic int exp_rel(int e, int ss, int len);
    int t = e;
    for (int s = ss; s < ss + len; s++) if (s <= t) t++;
    return t;
  endfunction

  task automatic clear_obs();
    wr_q.delete();
    addr_q.delete();
    ce_c.delete();
    done_n = 0;
    done_rel = -1;
    viol = 0;
  endtask

  task automatic run_tile(input logic [AW-1:0] base, input int ss, input int len, input int lane, input int bad_rel);
    logic [DW-1:0] word;
    int k;
    clear_obs();
    @(posedge clk); #1;
    start_i = 1'b1;
    base_addr_i = base;
    t0 = cyc;
    for (int r = 1; r < N + P + len + 5; r++) begin
      @(posedge clk); #1;
      start_i = (r == bad_rel);
      base_addr_i = base + AW'(9);
      full_i = (r >= ss && r < ss + len) ? P'(1) << lane : '0;
      if (r == 1) check("busy_c1", busy_o, 1);
    end
    full_i = '0;
    start_i = 1'b0;
    check("idle_after", busy_o, 0);
    check("n_reads", addr_q.size(), N);
    foreach (addr_q[j]) begin
      check("rd_addr", addr_q[j], (int'(base) + j) % 128);
      check("rd_cyc", ce_c[j], exp_rel(1 + j, ss, len));
    end
    for (int i = 0; i < P; i++) begin
      k = 0;
      foreach (wr_q[j])
        if (wr_q[j].lane == i) begin
          if (k < N) begin
            word = mem[AW'(int'(base) + k)];
            check("wdata", wr_q[j].data, word[DW-1-i*W -: W]);
            check("wr_cyc", wr_q[j].rel, exp_rel(2 + k + i, ss, len));
          end
          k++;
        end
      check("n_writes", k, N);
    end
    check("done_n", done_n, 1);
    check("done_cyc", done_rel, exp_rel(N + P, ss, len));
    check("full_write", viol, 0);
  endtask

  initial begin
    logic [DW2-1:0] wb;
    for (int a = 0; a < 128; a++) begin
      mem[a] = $urandom;
      mem_b[a] = {$urandom, $urandom, $urandom, $urandom};
    end
    mem_q_i = $urandom | 32'h1;
    q_b = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < P2; i++) begin
      first_b[i] = -1;
      cnt_b[i] = 0;
      data_b[i] = -1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_ce", mem_ce_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_wen", wen_o, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    rst_n = 1'b1;
    run_tile(7'd5, 0, 0, 0, 0);
    run_tile(7'd126, 0, 0, 0, 0);
    run_tile(7'd127, 0, 0, 0, 0);
    run_tile(AW'($urandom), $urandom_range(2, 5), 3, 2, 0);
    for (int t = 0; t < 4; t++)
      run_tile(AW'($urandom), $urandom_range(2, 5), $urandom_range(0, 3), $urandom_range(0, P - 1), 0);
    run_tile(AW'($urandom), 0, 0, 0, 2);
    run_tile(AW'($urandom), 3, 2, 1, 2);
    run_tile(AW'($urandom), 0, 0, 0, N + P);
    clear_obs();
    @(posedge clk); #1;
    start_i = 1'b1;
    base_addr_i = 7'd40;
    t0 = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (N + 1) @(posedge clk);
    #1;
    check("pre_rst_busy", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ce", mem_ce_o, 0);
    check("mid_rst_addr", mem_addr_o, 0);
    check("mid_rst_wen", wen_o, 0);
    check("mid_rst_wdata", wdata_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_done", done_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_done_rst", done_n, 0);
    check("idle_rst", busy_o, 0);
    run_tile(7'd5, 0, 0, 0, 0);
    @(posedge clk); #1;
    start_b = 1'b1;
    base_b = AW'($urandom);
    tb0 = cyc;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    wb = mem_b[base_b];
    check("b_ce_n", ce_b_n, 1);
    check("b_ce_cyc", ce_b_rel, 1);
    check("b_done_cyc", done_b_rel, 17);
    check("b_busy_end", busy_b, 0);
    for (int i = 0; i < P2; i++) begin
      check("b_n_writes", cnt_b[i], 1);
      check("b_wr_cyc", first_b[i], 2 + i);
      check("b_wdata", data_b[i], wb[DW2-1-i*W -: W]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sa_input_feeder.md
# sa_input_feeder

Reads a tile of `NUM_ROWS` packed vectors from an on-chip BRAM and writes them into the `PE_SIZE` per-lane input FIFOs of the systolic array. Each lane is skewed: lane i is delayed by i cycles, producing the diagonal wavefront the array consumes. It is the transmit-side counterpart of the output data mover, which un-skews array results back into memory. It sits between the operand BRAM and the row FIFOs, and is started once per tile by the GEMM controller.

## Interface
- `FIFO_DATA_WIDTH`, 8: element width per lane.
- `PE_SIZE`, 16: number of lanes (array rows).
- `MEM_ADDR_WIDTH`, 7: BRAM address width.
- `MEM_DATA_WIDTH`, 128: BRAM word width; must equal `PE_SIZE*FIFO_DATA_WIDTH`.
- `NUM_ROWS`, 16: words read per tile (≥1).

Ports:
- `clk`, in, 1: single clock. All logic on rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start_i`, in, 1: one-cycle start pulse. Ignored while `busy_o`=1.
- `base_addr_i`, in, `MEM_ADDR_WIDTH`: first word address. Sampled with `start_i`.
- `mem_ce_o`, out, 1: BRAM read enable.
- `mem_addr_o`, out, `MEM_ADDR_WIDTH`: BRAM read address.
- `mem_q_i`, in, `MEM_DATA_WIDTH`: BRAM read data, 1-cycle latency. Holds its value while `mem_ce_o`=0.
- `full_i`, in, `PE_SIZE`: per-lane FIFO full flags.
- `wen_o`, out, `PE_SIZE`: per-lane FIFO write enables.
- `wdata_o`, out, `FIFO_DATA_WIDTH*PE_SIZE`: per-lane write data.
- `busy_o`, out, 1: tile in progress.
- `done_o`, out, 1: one-cycle pulse when the tile is finished.

## Operation
- Lane mapping, MSB-first: lane i occupies `[MEM_DATA_WIDTH-1-i*FIFO_DATA_WIDTH -: FIFO_DATA_WIDTH]` in both `mem_q_i` and `wdata_o`.
- FSM states:
  - IDLE → READ on `start_i`.
  - READ → DRAIN after `NUM_ROWS` reads have been issued.
  - DRAIN → IDLE when lane `PE_SIZE-1` has written its last element; `done_o` pulses in that cycle.
- Read counter: `mem_addr_o` = `base_addr_i` + k for k = 0..`NUM_ROWS-1`, modulo 2^`MEM_ADDR_WIDTH` (address wrap is silent).
- Valid chain: a valid flag follows each read by one cycle (data return).
- Skew: lane i data and valid pass through a delay line of depth i. Lane 0 has no delay.
- `wen_o[i]` = lane-i delayed valid & ~stall.
- Stall: `stall` = |`full_i` (global and conservative). While stall is asserted:
  - `mem_ce_o`=0 and the read counter holds.
  - All valid and delay-line registers hold.
  - `wen_o` is all zero.
- Guarantee: no write ever occurs to a lane whose `full_i`=1. No element is lost or duplicated.
- Each lane receives exactly `NUM_ROWS` writes per tile, in address order.
- Reset values: `mem_ce_o`=0, `mem_addr_o`=0, `wen_o`=0, `wdata_o`=0, `busy_o`=0, `done_o`=0. FSM in IDLE; all delay lines cleared.
- Reset mid-tile: aborts immediately. No `done_o`; outstanding data is discarded.

## Timing
- Timing below assumes no stall. Cycle 0 is the cycle in which `start_i` is sampled.
- `busy_o`=1 from cycle 1 through the `done_o` cycle inclusive.
- `mem_ce_o`=1 in cycles 1..`NUM_ROWS`, with address base+(c-1).
- `wen_o[i]` for word k is asserted at cycle 2+k+i.
- Last write, and the `done_o` pulse, occur at cycle `NUM_ROWS+PE_SIZE`.
- Each stall cycle extends every later event by exactly one cycle.
- `start_i` in the `done_o` cycle is ignored. `start_i` one cycle later is accepted.

## Structure
- Shared package `sa_pkg`:
  - FSM state enum (IDLE/READ/DRAIN).
  - lane-slice index localparams.
  - `PE_SIZE`/`FIFO_DATA_WIDTH` defaults, shared with the output data mover.
- Sub-module `skew_delay_line`:
  - parameters `DEPTH` and `WIDTH`.
  - ports: enable (= ~stall), data+valid in, data+valid out.
  - `DEPTH`=0 passes straight through.
  - Instantiated once per lane with `DEPTH`=i.

## Test plan
- Basic tile: `PE_SIZE`=4, `NUM_ROWS`=3, base=5, BRAM word k holds lanes {k0,k1,k2,k3}.
  - Lane i receives k0..k2 lane-i bytes at cycles 2+k+i.
  - `done_o` at cycle 7.
  - Exactly 3 writes per lane.
- Address wrap: base=126, `NUM_ROWS`=4, `MEM_ADDR_WIDTH`=7 → addresses 126, 127, 0, 1.
- Backpressure: assert `full_i[2]` for 3 cycles mid-tile.
  - No `wen_o` during those cycles.
  - All FIFO contents match the no-stall run.
  - `done_o` is delayed by exactly 3 cycles.
- Start while busy: a second `start_i` with a different base during READ is ignored; one tile only.
- Reset mid-tile: `rst_n` low during DRAIN.
  - All outputs 0 immediately; no `done_o`.
  - A new start afterwards behaves as the basic tile.
- `NUM_ROWS`=1, `PE_SIZE`=16: single read at cycle 1; `wen_o[i]` at cycle 2+i; `done_o` at cycle 17.
